icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the pipeline's fetch port and the memory arbiter. Lookups for the PC are served in the same cycle on a hit. A miss stalls fetch through a two-state fill FSM that reads one word from memory and installs it. The datapath treats `ihit` as its fetch-valid, so the PC holds until `ihit` is asserted.

## Interface
- `SETS`, default 16, number of one-word frames; power of two, minimum 2.
- `CLK` in 1: clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `imemREN` in 1: fetch request from the datapath.
- `imemaddr` in 32: fetch byte address (word_t).
- `ihit` out 1: the `imemload` value is valid this cycle.
- `imemload` out 32: instruction word.
- `iREN` out 1: memory read request to the arbiter.
- `iaddr` out 32: memory read address.
- `iwait` in 1: arbiter busy; data is not yet valid.
- `iload` in 32: memory read data, valid when `iREN & ~iwait`.
- `hit_count` out 32: hit counter (see Configuration).
- `miss_count` out 32: miss counter (see Configuration).

## Operation
- **Address split:** bytoff = `[1:0]` (ignored), idx = `[IW+1:2]`, tag = `[31:IW+2]`, where IW = log2(SETS).
- **Frame contents:** `valid`, tag, and a 32-bit data word. All `valid` bits clear on reset. Tag and data are not reset.
- **FSM states:** `IDLE` and `FETCH`.
- **IDLE, hit:** a hit is `imemREN & valid[idx] & tag match`. On a hit, `ihit=1` and `imemload=data[idx]`, both combinational.
- **IDLE, miss:** a miss is `imemREN` without a hit. On a miss, latch `imemaddr` into `miss_addr`, go to `FETCH`, and keep `ihit=0`.
- **IDLE, no request:** when `imemREN=0`, `ihit=0`, `iREN=0`, and the FSM stays in `IDLE`.
- **FETCH:** drive `iREN=1` and `iaddr=miss_addr`, with `ihit=0`.
- **FETCH completion:** when `iwait=0`, write `{valid=1, tag, iload}` into frame `miss_addr.idx` and return to `IDLE`.
- **No fill bypass:** the requested word is delivered as a hit in the cycle after the fill.
- **`imemaddr` changes during FETCH** (redirect): the fill for `miss_addr` still completes. The new address is looked up from `IDLE` afterwards.
- **`imemREN` drops during FETCH:** the fill still completes. The memory transaction is never abandoned.
- **Replacement:** the frame is overwritten unconditionally. Conflicting addresses with the same idx evict each other.
- **Writes:** the cache has no write path. Self-modifying code is unsupported.

## Timing
- **Reset values:** state `IDLE`, all `valid=0`, `ihit=0`, `iREN=0`, `iaddr=0`, `imemload=0` (driven 0 when not hitting), `hit_count=0`, `miss_count=0`.
- **Hit latency:** 0 cycles (combinational from `imemaddr`).
- **Miss latency:** N+2 cycles from the request to `ihit`, where N is the number of `iwait=1` cycles:
  - 1 cycle: `IDLE` detects the miss.
  - N+1 cycles: `FETCH`.
  - `ihit` then asserts in `IDLE`.
- **Memory handshake:** `iREN`/`iaddr` stay stable for the whole of `FETCH`. Data is sampled on the rising edge where `iwait=0`.
- **Reset during FETCH:** the FSM returns to `IDLE` immediately, no frame is written, and `iREN` drops asynchronously.

## Configuration
- **`ICACHE_STATS_EN` defined:**
  - `hit_count` increments each cycle `ihit=1`.
  - `miss_count` increments on each `IDLE→FETCH` transition.
  - Both counters are 32-bit and saturate at 0xFFFFFFFF.
- **`ICACHE_STATS_EN` undefined:** both ports are tied to 0 and no counter flops are synthesised.

## Structure
- **Shared package entries in `cpu_types_pkg`:**
  - `icachef_t` packed struct `{tag, idx, bytoff}`, sized from a package constant `IIDX_W=4`.
  - `icache_frame_t` `{valid, tag, data}`.
  - `icache_state_t` enum `{IDLE, FETCH}`.
- **Sub-module `icache_stats`:** holds both counters. Instantiated only under `ICACHE_STATS_EN`.
- **Top-level connection:** the top-level cache wrapper connects the ports to `datapath_cache_if.icache` and `caches_if.icache`.

## Test plan
- **Cold miss:** reset, then `imemREN=1`, `imemaddr=0x00000000`.
  - Cycle 1: `FETCH`, with `iREN=1` and `iaddr=0`.
  - Memory holds `iwait=1` for 2 cycles, then returns 0x8C010004 with `iwait=0`.
  - Next cycle: `ihit=1` and `imemload=0x8C010004`.
- **Warm hit:** re-request 0x00000000 → `ihit=1` in the same cycle with `iREN=0`.
- **Conflict eviction:** request 0x00000040 (idx 0, different tag) → miss and fill with 0x20020001. Re-request 0x00000000 → miss again.
- **Redirect:** change `imemaddr` from 0x4 to 0x100 during `FETCH`.
  - Fill for 0x4 completes, and frame 1 becomes valid.
  - Next cycle: miss on 0x100.
  - A later request to 0x4 hits.
- **Reset during fill:** assert `nRST=0` while in `FETCH` with `iwait=1` → `iREN=0` immediately. After release, 0x4 misses.
- **Counters:** with `ICACHE_STATS_EN`, 3 misses and 5 hit cycles → `miss_count=3`, `hit_count=5`. Without the macro, both read 0.

Source files
------------

// File: rtl/icache_pkg.sv
`default_nettype none
//==============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU types used by the instruction cache: the word
//               type, the fetch address split, the frame layout and the fill
//               FSM state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Default cache geometry: 16 one-word frames.
    localparam int IIDX_W = 4;
    localparam int IBYT_W = 2;
    localparam int ITAG_W = 32 - IIDX_W - IBYT_W;

    // Fetch byte address viewed as cache fields.
    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

    // One cache frame.
    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

    // Fill FSM states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/icache_if.sv
`default_nettype none
//==============================================================================
// Module      : datapath_cache_if / caches_if
// Description : Fetch-side bus (datapath <-> icache) and memory-side bus
//               (icache <-> memory arbiter).
// Revision    : 1.0 - initial release
//==============================================================================
interface datapath_cache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;

    // Datapath drives the fetch request and consumes the instruction.
    modport datapath (
        output imemREN, imemaddr,
        input  ihit, imemload
    );

    // Cache serves the fetch request.
    modport icache (
        input  imemREN, imemaddr,
        output ihit, imemload
    );
endinterface : datapath_cache_if

interface caches_if;
    import cpu_types_pkg::*;

    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    // Cache issues memory reads.
    modport icache (
        output iREN, iaddr,
        input  iwait, iload
    );

    // Arbiter answers memory reads.
    modport arbiter (
        input  iREN, iaddr,
        output iwait, iload
    );
endinterface : caches_if
`default_nettype wire

// File: rtl/icache_stats.sv
`default_nettype none
//==============================================================================
// Module      : icache_stats
// Description : Saturating 32-bit hit and miss counters for the instruction
//               cache. Only instantiated when ICACHE_STATS_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
module icache_stats
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  hit,
    input  logic  miss,
    output word_t hit_count,
    output word_t miss_count
);

    word_t r_hits;
    word_t r_misses;

    // Count hit cycles and miss events, holding at all-ones instead of wrapping.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            if (hit && (r_hits != '1)) begin
                r_hits <= r_hits + 32'd1;
            end
            if (miss && (r_misses != '1)) begin
                r_misses <= r_misses + 32'd1;
            end
        end
    end

    assign hit_count  = r_hits;
    assign miss_count = r_misses;

endmodule : icache_stats
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
//==============================================================================
// Module      : icache
// Description : Direct-mapped, read-only instruction cache. Hits are served
//               combinationally; a miss runs a two-state fill FSM that reads
//               one word from memory, installs it and lets the lookup hit on
//               the following cycle (no fill bypass).
//               Optional macro ICACHE_STATS_EN adds hit/miss counters;
//               otherwise hit_count/miss_count are tied to zero.
// Revision    : 1.0 - initial release
//==============================================================================
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16
)(
    input  logic             CLK,
    input  logic             nRST,
    datapath_cache_if.icache dcif,
    caches_if.icache         cif,
    output word_t            hit_count,
    output word_t            miss_count
);

    localparam int IW = $clog2(SETS);
    localparam int TW = 32 - IW - 2;

    // Frame storage: valid bits are reset, tag and data are not.
    logic [SETS-1:0] r_valid;
    logic [TW-1:0]   r_tag  [SETS];
    word_t           r_data [SETS];

    icache_state_t r_state;
    word_t         r_miss_addr;
    logic          r_iren;

    logic [IW-1:0] w_idx;
    logic [TW-1:0] w_tag;
    logic [IW-1:0] w_fill_idx;
    logic [TW-1:0] w_fill_tag;
    logic          w_hit;
    logic          w_miss;
    logic          w_fill;

    assign w_idx      = dcif.imemaddr[IW+1:2];
    assign w_tag      = dcif.imemaddr[31:IW+2];
    assign w_fill_idx = r_miss_addr[IW+1:2];
    assign w_fill_tag = r_miss_addr[31:IW+2];

    // Lookups are only honoured in IDLE; a FETCH in progress never hits.
    assign w_hit  = (r_state == IDLE) && dcif.imemREN && r_valid[w_idx]
                    && (r_tag[w_idx] == w_tag);
    assign w_miss = (r_state == IDLE) && dcif.imemREN && !w_hit;
    assign w_fill = (r_state == FETCH) && !cif.iwait;

    // Fill FSM: latch the missing address, hold the read until memory answers,
    // then mark the frame valid. Reset aborts the fill without writing.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
            r_iren      <= 1'b0;
            r_valid     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_miss_addr <= dcif.imemaddr;
                        r_iren      <= 1'b1;
                        r_state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (!cif.iwait) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        r_iren              <= 1'b0;
                        r_state             <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_iren  <= 1'b0;
                end
            endcase
        end
    end

    // Install tag and data on the edge where memory data is valid.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= cif.iload;
        end
    end

    assign cif.iREN      = r_iren;
    assign cif.iaddr     = r_miss_addr;
    assign dcif.ihit     = w_hit;
    assign dcif.imemload = w_hit ? r_data[w_idx] : '0;

`ifdef ICACHE_STATS_EN
    icache_stats u_stats (
        .CLK        (CLK),
        .nRST       (nRST),
        .hit        (w_hit),
        .miss       (w_miss),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule : icache
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
//==============================================================================
// Module      : tb_icache
// Description : Self-checking bench for icache: a memory model with a
//               programmable wait count answers fills, and expected
//               instruction words are queued as fetches are issued and
//               compared when the cache reports a hit.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_icache;
    import cpu_types_pkg::*;

    logic  CLK;
    logic  nRST;
    word_t hit_count;
    word_t miss_count;

    datapath_cache_if dcif ();
    caches_if         cif ();

    icache #(.SETS(16)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .dcif       (dcif),
        .cif        (cif),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    int    mem_waits = 2;
    int    e_hits = 0;
    int    e_miss = 0;
    word_t sbq [$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory image seen by the arbiter.
    function automatic word_t mem_word(input word_t a);
        case (a)
            32'h0000_0000: return 32'h8C01_0004;
            32'h0000_0040: return 32'h2002_0001;
            default:       return {a[15:0] ^ 16'h5A5A, 16'hBEEF};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model: holds iwait for mem_waits cycles of each read, then returns data.
    initial begin
        int m_cnt;
        m_cnt     = 0;
        cif.iwait = 1'b1;
        cif.iload = '0;
        forever begin
            @(negedge CLK);
            if (cif.iREN) begin
                cif.iwait = (m_cnt < mem_waits);
                cif.iload = cif.iwait ? 32'hDEAD_DEAD : mem_word(cif.iaddr);
                m_cnt++;
            end else begin
                m_cnt     = 0;
                cif.iwait = 1'b1;
            end
        end
    end

    // Pop the expected word for the current hit and compare it.
    task automatic consume(input string nm);
        word_t exp;
        exp = sbq.pop_front();
        check({nm, " ihit"}, dcif.ihit, 1'b1);
        check({nm, " data"}, dcif.imemload, exp);
    endtask

    // One fetch: either an immediate hit or a miss with measured latency.
    task automatic fetch(input word_t a, input bit miss, input string nm);
        int k;
        bit got;
        @(negedge CLK);
        dcif.imemREN  = 1'b1;
        dcif.imemaddr = a;
        sbq.push_back(mem_word(a));
        e_hits++;
        #1;
        if (!miss) begin
            check({nm, " iREN"}, cif.iREN, 1'b0);
            consume(nm);
        end else begin
            e_miss++;
            check({nm, " early ihit"}, dcif.ihit, 1'b0);
            k   = 0;
            got = 1'b0;
            while (!got && k < 40) begin
                @(negedge CLK);
                #1;
                k++;
                if (k == 1) begin
                    check({nm, " iREN"}, cif.iREN, 1'b1);
                    check({nm, " iaddr"}, cif.iaddr, a);
                end
                got = dcif.ihit;
            end
            check({nm, " latency"}, k, mem_waits + 2);
            consume(nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  got;
        nRST          = 1'b0;
        dcif.imemREN  = 1'b0;
        dcif.imemaddr = '0;
        repeat (3) @(negedge CLK);
        #1;
        check("rst ihit", dcif.ihit, 1'b0);
        check("rst iREN", cif.iREN, 1'b0);
        check("rst iaddr", cif.iaddr, 32'h0);
        check("rst imemload", dcif.imemload, 32'h0);
        check("rst hit_count", hit_count, 32'h0);
        check("rst miss_count", miss_count, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        // Cold miss, warm hit, conflict eviction.
        mem_waits = 2;
        fetch(32'h0000_0000, 1'b1, "cold");
        fetch(32'h0000_0000, 1'b0, "warm");
        mem_waits = 0;
        fetch(32'h0000_0040, 1'b1, "evict40");
        mem_waits = 1;
        fetch(32'h0000_0000, 1'b1, "remiss0");
        fetch(32'h0000_0040, 1'b1, "remiss40");

        // Redirect during FETCH: fill for 0x4 completes, then 0x100 misses.
        mem_waits = 2;
        @(negedge CLK);
        dcif.imemREN  = 1'b1;
        dcif.imemaddr = 32'h0000_0004;
        sbq.push_back(mem_word(32'h0000_0004));
        #1;
        check("redir early ihit", dcif.ihit, 1'b0);
        @(negedge CLK);
        #1;
        check("redir iREN", cif.iREN, 1'b1);
        check("redir iaddr", cif.iaddr, 32'h0000_0004);
        dcif.imemaddr = 32'h0000_0100;
        void'(sbq.pop_back());
        sbq.push_back(mem_word(32'h0000_0100));
        k   = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(negedge CLK);
            #1;
            k++;
            got = !cif.iREN;
        end
        check("redir fill done", got, 1'b1);
        check("redir 100 miss", dcif.ihit, 1'b0);
        @(negedge CLK);
        #1;
        check("redir2 iREN", cif.iREN, 1'b1);
        check("redir2 iaddr", cif.iaddr, 32'h0000_0100);
        k   = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(negedge CLK);
            #1;
            k++;
            got = dcif.ihit;
        end
        consume("redir100");
        fetch(32'h0000_0004, 1'b0, "redir4hit");

        // Reset during a fill: iREN drops at once, no frame is written.
        mem_waits = 5;
        @(negedge CLK);
        dcif.imemREN  = 1'b1;
        dcif.imemaddr = 32'h0000_0044;
        sbq.push_back(mem_word(32'h0000_0044));
        @(negedge CLK);
        #1;
        check("rstfill iREN", cif.iREN, 1'b1);
        dcif.imemREN = 1'b0;
        nRST         = 1'b0;
        #1;
        check("rstfill async iREN", cif.iREN, 1'b0);
        check("rstfill iaddr", cif.iaddr, 32'h0);
        sbq.delete();
        @(negedge CLK);
        nRST   = 1'b1;
        e_hits = 0;
        e_miss = 0;

        // After reset 0x4 misses again; then build 3 misses / 5 hit cycles.
        mem_waits = 1;
        fetch(32'h0000_0004, 1'b1, "post4");
        fetch(32'h0000_0008, 1'b1, "post8");
        mem_waits = 3;
        fetch(32'h0000_000C, 1'b1, "postC");
        fetch(32'h0000_0004, 1'b0, "hit4");
        fetch(32'h0000_0008, 1'b0, "hit8");
        @(negedge CLK);
        dcif.imemREN = 1'b0;
        @(negedge CLK);
        #1;
        check("idle ihit", dcif.ihit, 1'b0);
        check("idle imemload", dcif.imemload, 32'h0);
        check("idle iREN", cif.iREN, 1'b0);
`ifdef ICACHE_STATS_EN
        check("hit_count", hit_count, e_hits);
        check("miss_count", miss_count, e_miss);
`else
        check("hit_count", hit_count, 32'h0);
        check("miss_count", miss_count, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_icache
`default_nettype wire
